// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the scanned 7-segment display arbiter.
package seg_disp_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  localparam int unsigned DIGITS    = 8;
  localparam int unsigned DIGIT_W   = $clog2(DIGITS);
  localparam int unsigned SEG_W     = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // One-hot digit enable for a digit index.
  function automatic logic [DIGITS-1:0] digit_onehot(input logic [DIGIT_W-1:0] d);
    return DIGITS'(1) << d;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Digit-slot prescaler: counts SCAN_DIV clk cycles per slot.
// tick marks the last cycle of a slot; blank_window flags that the next
// cycle lies in the final quarter of a slot (used to blank registered outputs).
module seg_scan_tick #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic blank_window
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax     = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankStart = CntW'(SCAN_DIV - SCAN_DIV / 4);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero while cleared, wrap on tick.
  always_comb begin
    tick = (cnt_q == CntMax) && !clear;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    blank_window = (cnt_d >= BlankStart);
  end

  // Prescaler state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing an 8-digit scanned 7-segment display between
// two clients. The winner's frame is snapshotted at each frame boundary and
// scanned digit by digit; ownership only changes at frame boundaries.
// Optional macro SEG_ARB_BLANK_EN: blank bit_sel during the last quarter of
// every digit slot for anti-ghosting.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned HOLD_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [DIGITS*SEG_W-1:0] frame0,
  input  logic [DIGITS*SEG_W-1:0] frame1,
  output logic [1:0]              gnt,
  output logic [DIGITS-1:0]       bit_sel,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    frame_done
);

  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

  state_e                    state_q, state_d;
  logic [1:0]                gnt_q, gnt_d;
  logic [DIGIT_W-1:0]        digit_q, digit_d;
  logic [HoldW-1:0]          hold_q, hold_d;
  logic                      last_q, last_d;
  logic [DIGITS*SEG_W-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]         bit_sel_q, bit_sel_d;
  logic [SEG_W-1:0]          seg_q, seg_d;
  logic                      done_q, done_d;

  logic tick;
  logic blank_window;
  logic boundary;
  logic owner;
  logic own_req;
  logic oth_req;
  logic win;

  seg_scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .clear       (state_q == StIdle),
    .tick        (tick),
    .blank_window(blank_window)
  );

`ifndef SEG_ARB_BLANK_EN
  logic unused_blank;
  assign unused_blank = blank_window;
`endif

  // Arbitration, digit sequencing and next-state for registered outputs.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    digit_d  = digit_q;
    hold_d   = hold_q;
    last_d   = last_q;
    shadow_d = shadow_q;

    boundary = (state_q == StScan) && tick && (digit_q == DIGIT_W'(DIGITS - 1));
    owner    = gnt_q[1];
    own_req  = req[owner];
    oth_req  = req[~owner];
    // On a tie the client that was not granted last wins.
    win      = (req == 2'b11) ? ~last_q : req[1];

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d  = StScan;
          gnt_d    = win ? 2'b10 : 2'b01;
          last_d   = win;
          shadow_d = win ? frame1 : frame0;
          digit_d  = '0;
          hold_d   = '0;
        end
      end
      StScan: begin
        if (boundary) begin
          digit_d = '0;
          if (!own_req && !oth_req) begin
            state_d = StIdle;
            gnt_d   = 2'b00;
            hold_d  = '0;
          end else if (own_req && !oth_req) begin
            if (32'(hold_q) < HOLD_FRAMES) begin
              hold_d = hold_q + 1'b1;
            end
            shadow_d = owner ? frame1 : frame0;
          end else if (!own_req || (32'(hold_q) + 1 >= HOLD_FRAMES)) begin
            gnt_d    = ~gnt_q;
            last_d   = ~owner;
            hold_d   = '0;
            shadow_d = owner ? frame0 : frame1;
          end else begin
            hold_d   = hold_q + 1'b1;
            shadow_d = owner ? frame1 : frame0;
          end
        end else if (tick) begin
          digit_d = digit_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StScan) begin
      bit_sel_d = digit_onehot(digit_d);
      seg_d     = shadow_d[{digit_d, 3'b000} +: SEG_W];
    end else begin
      bit_sel_d = '0;
      seg_d     = SEG_BLANK;
    end
`ifdef SEG_ARB_BLANK_EN
    if (blank_window) begin
      bit_sel_d = '0;
    end
`endif
    done_d = boundary;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      digit_q   <= '0;
      hold_q    <= '0;
      last_q    <= 1'b1;
      shadow_q  <= '0;
      bit_sel_q <= '0;
      seg_q     <= SEG_BLANK;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      digit_q   <= digit_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      shadow_q  <= shadow_d;
      bit_sel_q <= bit_sel_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign gnt        = gnt_q;
  assign bit_sel    = bit_sel_q;
  assign seg_out    = seg_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed phases followed by
// random request/frame/reset traffic, compared every cycle against a
// frame-position model of the display.
module tb_seg_display_arbiter;

  localparam int unsigned SD = 4;
  localparam int unsigned HF = 2;
  localparam int FRAME_CYC = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] frame0;
  logic [63:0] frame1;
  logic [1:0]  gnt;
  logic [7:0]  bit_sel;
  logic [7:0]  seg_out;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Model: owner (-1 idle), position within frame in cycles, frames held.
  int          m_owner = -1;
  int          m_t     = 0;
  int          m_held  = 0;
  int          m_last  = 1;
  logic [63:0] m_shadow = '0;
  logic        m_done  = 1'b0;
  bit          m_valid = 1'b0;

  seg_display_arbiter #(
    .SCAN_DIV   (SD),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .frame0    (frame0),
    .frame1    (frame1),
    .gnt       (gnt),
    .bit_sel   (bit_sel),
    .seg_out   (seg_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic model_edge(input logic r, input logic [1:0] rq,
                            input logic [63:0] f0, input logic [63:0] f1);
    bit own, oth;
    if (r) begin
      m_owner = -1; m_t = 0; m_held = 0; m_last = 1; m_done = 1'b0; m_valid = 1'b1;
    end else if (m_owner < 0) begin
      m_done = 1'b0;
      if (rq != 2'b00) begin
        m_owner  = (rq == 2'b11) ? (1 - m_last) : ((rq == 2'b10) ? 1 : 0);
        m_last   = m_owner;
        m_shadow = (m_owner == 1) ? f1 : f0;
        m_t      = 0;
        m_held   = 0;
      end
    end else begin
      m_done = (m_t == FRAME_CYC - 1);
      if (!m_done) begin
        m_t++;
      end else begin
        own = rq[m_owner];
        oth = rq[1 - m_owner];
        if (!own && !oth) begin
          m_owner = -1;
          m_held  = 0;
        end else if (own && !oth) begin
          if (m_held < HF) m_held++;
        end else if (!own || (m_held + 1 >= HF)) begin
          m_owner = 1 - m_owner;
          m_last  = m_owner;
          m_held  = 0;
        end else begin
          m_held++;
        end
        m_t = 0;
        if (m_owner >= 0) m_shadow = (m_owner == 1) ? f1 : f0;
      end
    end
  endtask

  // Check outputs at the falling edge, then drive inputs for the next edge.
  task automatic step(input logic r, input logic [1:0] rq,
                      input logic [63:0] f0, input logic [63:0] f1);
    logic [1:0]  e_gnt;
    logic [7:0]  e_bs;
    logic [7:0]  e_seg;
    logic [63:0] sh;
    int          dig;
    int          pos;
    @(negedge clk);
    if (m_valid) begin
      e_gnt = 2'b00;
      e_bs  = 8'h00;
      e_seg = 8'h00;
      if (m_owner >= 0) begin
        e_gnt = (m_owner == 1) ? 2'b10 : 2'b01;
        dig   = m_t / SD;
        pos   = m_t % SD;
        e_bs  = 8'h01 << dig;
`ifdef SEG_ARB_BLANK_EN
        if (pos >= int'(SD - SD / 4)) e_bs = 8'h00;
`endif
        sh    = m_shadow >> (8 * dig);
        e_seg = sh[7:0];
      end
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("bit_sel", 64'(bit_sel), 64'(e_bs));
      check("seg_out", 64'(seg_out), 64'(e_seg));
      check("frame_done", 64'(frame_done), 64'(m_done));
    end
    rst    = r;
    req    = rq;
    frame0 = f0;
    frame1 = f1;
    model_edge(r, rq, f0, f1);
  endtask

  task automatic run(input int n, input logic r, input logic [1:0] rq,
                     input logic [63:0] f0, input logic [63:0] f1);
    for (int i = 0; i < n; i++) step(r, rq, f0, f1);
  endtask

  localparam logic [63:0] F0A = 64'h0102030405060708;
  localparam logic [63:0] F0B = 64'h1112131415161718;
  localparam logic [63:0] F1A = 64'hA1A2A3A4A5A6A7A8;

  initial begin
    logic [1:0]  rq;
    logic [63:0] f0;
    logic [63:0] f1;
    logic        r;
    rst = 1'b1; req = 2'b00; frame0 = '0; frame1 = '0;

    run(3, 1'b1, 2'b00, F0A, F1A);
    // Idle with no requests.
    run(100, 1'b0, 2'b00, F0A, F1A);
    // Single client scanning.
    run(80, 1'b0, 2'b01, F0A, F1A);
    run(40, 1'b0, 2'b00, F0A, F1A);
    // Both requesting: alternation after hold frames.
    run(200, 1'b0, 2'b11, F0A, F1A);
    run(40, 1'b0, 2'b00, F0A, F1A);
    // Owner 0 drops mid-frame while client 1 requests.
    run(44, 1'b0, 2'b01, F0A, F1A);
    run(60, 1'b0, 2'b10, F0A, F1A);
    run(40, 1'b0, 2'b00, F0A, F1A);
    // Frame change mid-frame.
    run(10, 1'b0, 2'b01, F0A, F1A);
    run(60, 1'b0, 2'b01, F0B, F1A);
    // Reset pulse mid-frame.
    run(21, 1'b0, 2'b01, F0A, F1A);
    run(1, 1'b1, 2'b01, F0A, F1A);
    run(40, 1'b0, 2'b01, F0A, F1A);

    // Random traffic.
    rq = 2'b00; f0 = F0A; f1 = F1A;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 23) == 0) rq = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) f0 = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) f1 = {$urandom, $urandom};
      r = ($urandom_range(0, 1499) == 0);
      step(r, rq, f0, f1);
    end
    step(1'b0, 2'b00, f0, f1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
